// File: rtl/alu_program_sequencer.sv
// Program buffer and issue sequencer for the ALU/register-file datapath.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   prog_valid/ready    append one (operator, operand) pair to the buffer
//   prog_operator/operand  the pair offered for appending
//   clear, start        empty the buffer / run the program (idle only)
//   pause               freeze issue while running
//   busy, done          run in progress / one-cycle completion pulse
//   prog_count          number of loaded entries
//   alu_operator/operand/issue   registered command outputs to the datapath
//   alu_read_data/flags  datapath read-back, sampled at end of drain
//   result_data/flags   captured read-back
module alu_program_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int RESULT_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] NOP_OPERATOR = 16'hF000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    prog_valid,
    output logic                    prog_ready,
    input  logic [DATA_WIDTH-1:0]   prog_operator,
    input  logic [DATA_WIDTH-1:0]   prog_operand,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    pause,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(DEPTH):0]  prog_count,
    output logic [DATA_WIDTH-1:0]   alu_operator,
    output logic [DATA_WIDTH-1:0]   alu_operand,
    output logic                    alu_issue,
    input  logic [DATA_WIDTH-1:0]   alu_read_data,
    input  logic [3:0]              alu_flags,
    output logic [DATA_WIDTH-1:0]   result_data,
    output logic [3:0]              result_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [DATA_WIDTH-1:0] op_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] opd_mem [DEPTH];

    // pc is the index of the next entry to issue
    logic [CW-1:0]         pc, pc_n;
    logic [LW-1:0]         drain, drain_n;
    logic [CW-1:0]         count_n;
    logic [DATA_WIDTH-1:0] op_n, opd_n;
    logic                  issue_n, busy_n, done_n;
    logic [DATA_WIDTH-1:0] rdata_n;
    logic [3:0]            rflags_n;

    logic                  accept;
    logic [DATA_WIDTH-1:0] first_op, first_opd;

    assign prog_ready = (state == S_IDLE) && !clear
                        && (prog_count < CW'(DEPTH));
    assign accept     = prog_valid && prog_ready;

    // A word accepted alongside start may be the only entry; forward it
    // straight to the outputs since the buffer write lands on the same edge.
    assign first_op  = (prog_count == '0) ? prog_operator : op_mem[0];
    assign first_opd = (prog_count == '0) ? prog_operand  : opd_mem[0];

    always_ff @(posedge clk) begin
        if (accept) begin
            op_mem[prog_count[AW-1:0]]  <= prog_operator;
            opd_mem[prog_count[AW-1:0]] <= prog_operand;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        drain_n  = drain;
        count_n  = prog_count;
        op_n     = NOP_OPERATOR;
        opd_n    = '0;
        issue_n  = 1'b0;
        busy_n   = busy;
        done_n   = 1'b0;
        rdata_n  = result_data;
        rflags_n = result_flags;

        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    count_n = prog_count + 1'b1;
                end
                if (clear) begin
                    count_n = '0;
                end else if (start) begin
                    if (count_n != '0) begin
                        state_n = S_RUN;
                        busy_n  = 1'b1;
                        issue_n = 1'b1;
                        op_n    = first_op;
                        opd_n   = first_opd;
                        pc_n    = CW'(1);
                    end else begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // The last entry is already on the outputs; pause no longer
                // matters once nothing is left to issue.
                if (pc == prog_count) begin
                    state_n = S_DRAIN;
                    drain_n = LW'(RESULT_LATENCY - 1);
                end else if (!pause) begin
                    issue_n = 1'b1;
                    op_n    = op_mem[pc[AW-1:0]];
                    opd_n   = opd_mem[pc[AW-1:0]];
                    pc_n    = pc + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain == '0) begin
                    state_n  = S_DONE;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                    rdata_n  = alu_read_data;
                    rflags_n = alu_flags;
                end else begin
                    drain_n = drain - 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            pc           <= '0;
            drain        <= '0;
            prog_count   <= '0;
            alu_operator <= NOP_OPERATOR;
            alu_operand  <= '0;
            alu_issue    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_data  <= '0;
            result_flags <= '0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            drain        <= drain_n;
            prog_count   <= count_n;
            alu_operator <= op_n;
            alu_operand  <= opd_n;
            alu_issue    <= issue_n;
            busy         <= busy_n;
            done         <= done_n;
            result_data  <= rdata_n;
            result_flags <= rflags_n;
        end
    end

endmodule

// File: tb/tb_alu_program_sequencer.sv
// Scoreboard bench for alu_program_sequencer: the driver predicts issue
// words, their cycles and the captured results; a monitor pops and compares.
module tb_alu_program_sequencer;

    localparam int DW = 16;
    localparam int DEPTH = 16;
    localparam int RL = 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [DW-1:0] NOP = 16'hF000;

    typedef struct {
        logic [DW-1:0] op;
        logic [DW-1:0] opd;
        int            t;
    } iss_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [3:0]    flags;
        int            t;
    } res_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          prog_valid = 1'b0;
    logic          prog_ready;
    logic [DW-1:0] prog_operator = '0;
    logic [DW-1:0] prog_operand = '0;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] prog_count;
    logic [DW-1:0] alu_operator;
    logic [DW-1:0] alu_operand;
    logic          alu_issue;
    logic [DW-1:0] alu_read_data = '0;
    logic [3:0]    alu_flags = '0;
    logic [DW-1:0] result_data;
    logic [3:0]    result_flags;

    alu_program_sequencer #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .RESULT_LATENCY(RL),
        .NOP_OPERATOR(NOP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .prog_valid(prog_valid),
        .prog_ready(prog_ready),
        .prog_operator(prog_operator),
        .prog_operand(prog_operand),
        .clear(clear),
        .start(start),
        .pause(pause),
        .busy(busy),
        .done(done),
        .prog_count(prog_count),
        .alu_operator(alu_operator),
        .alu_operand(alu_operand),
        .alu_issue(alu_issue),
        .alu_read_data(alu_read_data),
        .alu_flags(alu_flags),
        .result_data(result_data),
        .result_flags(result_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    logic busy_exp = 1'b0;
    bit resp_fixed = 1'b0;

    iss_t iq[$];
    res_t rq[$];
    logic [DW-1:0] m_op[$];
    logic [DW-1:0] m_opd[$];
    logic [DW-1:0] last_data = '0;
    logic [3:0]    last_flags = '0;
    logic [DW-1:0] rd_hist[int];
    logic [3:0]    fl_hist[int];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Advance one edge; the responder presents a fresh read-back word each
    // cycle so the capture edge is pinned down exactly.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!resp_fixed) begin
            alu_read_data = DW'($urandom);
            alu_flags     = 4'($urandom);
        end
        rd_hist[cyc] = alu_read_data;
        fl_hist[cyc] = alu_flags;
    endtask

    always @(negedge clk) begin : monitor
        iss_t e;
        res_t r;
        if (!reset) begin
            if (alu_issue) begin
                if (iq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue: unexpected word %h/%h (cycle %0d)",
                             alu_operator, alu_operand, cyc);
                end else begin
                    e = iq.pop_front();
                    check("issue_operator", 32'(alu_operator), 32'(e.op));
                    check("issue_operand", 32'(alu_operand), 32'(e.opd));
                    check("issue_cycle", cyc, e.t);
                end
            end else begin
                check("idle_operator", 32'(alu_operator), 32'(NOP));
                check("idle_operand", 32'(alu_operand), 32'(0));
            end
            check("busy", 32'(busy), 32'(busy_exp));
            if (done) begin
                done_seen++;
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done: unexpected pulse (cycle %0d)", cyc);
                end else begin
                    r = rq.pop_front();
                    check("result_data", 32'(result_data), 32'(r.data));
                    check("result_flags", 32'(result_flags), 32'(r.flags));
                    check("done_cycle", cyc, r.t);
                end
            end
        end
    end

    task automatic load(input logic [DW-1:0] op, input logic [DW-1:0] opd);
        bit exp_rdy;
        exp_rdy = (m_op.size() < DEPTH);
        prog_valid = 1'b1;
        prog_operator = op;
        prog_operand = opd;
        #1;
        check("prog_ready", 32'(prog_ready), 32'(exp_rdy));
        tick();
        prog_valid = 1'b0;
        if (exp_rdy) begin
            m_op.push_back(op);
            m_opd.push_back(opd);
        end
        check("prog_count", 32'(prog_count), 32'(m_op.size()));
    endtask

    task automatic do_clear(input bit with_valid);
        clear = 1'b1;
        prog_valid = with_valid;
        prog_operator = DW'($urandom);
        #1;
        check("ready_during_clear", 32'(prog_ready), 32'(0));
        tick();
        clear = 1'b0;
        prog_valid = 1'b0;
        m_op.delete();
        m_opd.delete();
        #1;
        check("count_after_clear", 32'(prog_count), 32'(0));
        check("ready_after_clear", 32'(prog_ready), 32'(1));
    endtask

    // pmode: 0 no pause, 1 random pause, 2 pause on the first two
    // issue edges after the first word
    task automatic run(input int pmode, input bit inject, input bit add_word);
        int n, k, j, t_last, done_t, e_cyc;
        bit p;
        if (add_word) begin
            prog_valid = 1'b1;
            prog_operator = DW'($urandom);
            prog_operand = DW'($urandom);
            #1;
            check("ready_with_start", 32'(prog_ready),
                  32'(m_op.size() < DEPTH));
            if (m_op.size() < DEPTH) begin
                m_op.push_back(prog_operator);
                m_opd.push_back(prog_operand);
            end
        end
        n = m_op.size();
        start = 1'b1;
        if (n > 0) iq.push_back('{m_op[0], m_opd[0], cyc + 1});
        tick();
        start = 1'b0;
        prog_valid = 1'b0;
        e_cyc = cyc;
        if (n == 0) begin
            rq.push_back('{last_data, last_flags, e_cyc});
            tick();
            tick();
            check("empty_result_kept", 32'(result_data), 32'(last_data));
            check("empty_rq_drained", rq.size(), 0);
            return;
        end
        busy_exp = 1'b1;
        t_last = e_cyc;
        k = 1;
        j = 0;
        while (k < n) begin
            p = (pmode == 1) ? ($urandom_range(0, 2) == 0)
              : (pmode == 2) ? (j < 2) : 1'b0;
            pause = p;
            if (inject) begin
                start = 1'($urandom);
                clear = 1'($urandom);
                prog_valid = 1'($urandom);
                prog_operator = DW'($urandom);
                #1;
                check("ready_in_run", 32'(prog_ready), 32'(0));
            end
            if (!p) begin
                iq.push_back('{m_op[k], m_opd[k], cyc + 1});
                t_last = cyc + 1;
                k++;
            end
            tick();
            j++;
        end
        start = 1'b0;
        clear = 1'b0;
        prog_valid = 1'b0;
        done_t = t_last + RL + 1;
        while (cyc < done_t) begin
            pause = (pmode != 0) && 1'($urandom);
            tick();
        end
        pause = 1'b0;
        last_data = rd_hist[done_t - 1];
        last_flags = fl_hist[done_t - 1];
        rq.push_back('{last_data, last_flags, done_t});
        busy_exp = 1'b0;
        tick();
        tick();
        check("iq_drained", iq.size(), 0);
        check("rq_drained", rq.size(), 0);
        check("prog_count_kept", 32'(prog_count), 32'(n));
    endtask

    task automatic check_reset_values();
        check("rst_prog_ready", 32'(prog_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_prog_count", 32'(prog_count), 32'(0));
        check("rst_operator", 32'(alu_operator), 32'(NOP));
        check("rst_operand", 32'(alu_operand), 32'(0));
        check("rst_issue", 32'(alu_issue), 32'(0));
        check("rst_result_data", 32'(result_data), 32'(0));
        check("rst_result_flags", 32'(result_flags), 32'(0));
    endtask

    initial begin
        int n, d0;
        tick();
        tick();
        check_reset_values();
        reset = 1'b0;
        tick();

        resp_fixed = 1'b1;
        alu_read_data = 16'h00CD;
        alu_flags = 4'b0010;
        load(16'h1003, 16'h00AB);
        load(16'h0002, 16'h0100);
        load(16'h1004, 16'h0002);
        run(0, 1'b0, 1'b0);
        check("t1_result_data", 32'(result_data), 32'h00CD);
        check("t1_result_flags", 32'(result_flags), 32'h2);
        resp_fixed = 1'b0;

        run(2, 1'b0, 1'b0);

        do_clear(1'b0);
        run(0, 1'b0, 1'b0);

        load(DW'($urandom), DW'($urandom));
        load(DW'($urandom), DW'($urandom));
        run(0, 1'b0, 1'b1);

        run(1, 1'b1, 1'b0);

        do_clear(1'b0);
        for (int i = 0; i < DEPTH; i++) load(DW'($urandom), DW'($urandom));
        load(DW'($urandom), DW'($urandom));
        run(1, 1'b0, 1'b0);
        do_clear(1'b1);

        for (int r = 0; r < 6; r++) begin
            do_clear(1'b0);
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) load(DW'($urandom), DW'($urandom));
            run(1, 1'($urandom), 1'($urandom));
        end

        do_clear(1'b0);
        for (int i = 0; i < 3; i++) load(DW'($urandom), DW'($urandom));
        iq.push_back('{m_op[0], m_opd[0], cyc + 1});
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_exp = 1'b1;
        iq.push_back('{m_op[1], m_opd[1], cyc + 1});
        tick();
        #1;
        reset = 1'b1;
        #1;
        check_reset_values();
        iq.delete();
        rq.delete();
        m_op.delete();
        m_opd.delete();
        busy_exp = 1'b0;
        last_data = '0;
        last_flags = '0;
        tick();
        tick();
        reset = 1'b0;
        d0 = done_seen;
        repeat (6) tick();
        check("no_done_after_reset", done_seen, d0);
        check("count_after_reset", 32'(prog_count), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
